// File: rtl/led_pkg.sv
// Shared register map and control-field layout for the LED output-conditioning stage.
package led_pkg;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_PERIOD = 2'd1;
    localparam logic [1:0] ADDR_MASK   = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    localparam int CTRL_EN       = 0;
    localparam int CTRL_BLINK    = 1;
    localparam int CTRL_DUTY_LSB = 8;

    // CTRL reset value for the default 8-bit PWM configuration.
    localparam logic [31:0] CTRL_RESET = 32'h0000_FF01;

    // Enabled, blink off, duty all-ones, for any PWM width.
    function automatic logic [31:0] ctrl_reset_value(input int pwm_bits);
        logic [31:0] v;
        v = '0;
        v[CTRL_EN] = 1'b1;
        for (int i = 0; i < pwm_bits; i++) begin
            v[CTRL_DUTY_LSB + i] = 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/led_blink_timer.sv
// Blink half-period timer: phase toggles every PERIOD cycles and restarts high
// whenever PERIOD is rewritten.
module led_blink_timer
    import led_pkg::*;
#(
    parameter int PERIOD_BITS = 24
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [PERIOD_BITS-1:0] period,
    input  logic                   restart,
    output logic                   phase
);

    logic [PERIOD_BITS-1:0] blink_cnt;

    // A restart outranks a coincident terminal count so a rewrite never toggles.
    always_ff @(posedge clk) begin
        if (reset || restart || period == '0) begin
            blink_cnt <= '0;
            phase     <= 1'b1;
        end else if (blink_cnt == period - 1'b1) begin
            blink_cnt <= '0;
            phase     <= ~phase;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/led_pwm_blinker.sv
// LED output conditioning: global PWM dimming plus per-pin blink masking,
// configured through a zero-wait-state Avalon-MM slave.
module led_pwm_blinker
    import led_pkg::*;
#(
    parameter int NUM_LEDS    = 10,
    parameter int PWM_BITS    = 8,
    parameter int PERIOD_BITS = 24
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_LEDS-1:0] led_in,
    input  logic [1:0]          address,
    input  logic                chipselect,
    input  logic                write_n,
    input  logic [31:0]         writedata,
    output logic [31:0]         readdata,
    output logic [NUM_LEDS-1:0] led_out
);

    localparam logic [31:0] CTRL_INIT = ctrl_reset_value(PWM_BITS);

    logic                   enable;
    logic                   blink_en;
    logic [PWM_BITS-1:0]    duty;
    logic [PERIOD_BITS-1:0] period;
    logic [NUM_LEDS-1:0]    mask;
    logic [PWM_BITS-1:0]    pwm_cnt;
    logic                   phase;
    logic                   bus_write;
    logic                   period_write;
    logic                   pwm_on;
    logic [NUM_LEDS-1:0]    blink_gate;
    logic                   unused_wdata;

    assign bus_write    = chipselect && !write_n;
    assign period_write = bus_write && (address == ADDR_PERIOD);
    assign unused_wdata = ^writedata;

    always_ff @(posedge clk) begin
        if (reset) begin
            enable   <= CTRL_INIT[CTRL_EN];
            blink_en <= CTRL_INIT[CTRL_BLINK];
            duty     <= CTRL_INIT[CTRL_DUTY_LSB +: PWM_BITS];
            period   <= '0;
            mask     <= '0;
        end else if (bus_write) begin
            case (address)
                ADDR_CTRL: begin
                    enable   <= writedata[CTRL_EN];
                    blink_en <= writedata[CTRL_BLINK];
                    duty     <= writedata[CTRL_DUTY_LSB +: PWM_BITS];
                end
                ADDR_PERIOD: period <= writedata[PERIOD_BITS-1:0];
                ADDR_MASK:   mask   <= writedata[NUM_LEDS-1:0];
                default:     ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
        end
    end

    led_blink_timer #(
        .PERIOD_BITS (PERIOD_BITS)
    ) u_blink_timer (
        .clk     (clk),
        .reset   (reset),
        .period  (period),
        .restart (period_write),
        .phase   (phase)
    );

    // Full duty is forced on so the LED never drops out at the counter wrap.
    assign pwm_on     = (duty == '1) || (pwm_cnt < duty);
    assign blink_gate = ~(mask & {NUM_LEDS{blink_en}}) | {NUM_LEDS{phase}};

    always_ff @(posedge clk) begin
        if (reset) begin
            led_out <= '0;
        end else if (enable) begin
            led_out <= led_in & {NUM_LEDS{pwm_on}} & blink_gate;
        end else begin
            led_out <= '0;
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_CTRL: begin
                readdata[CTRL_EN]                     = enable;
                readdata[CTRL_BLINK]                  = blink_en;
                readdata[CTRL_DUTY_LSB +: PWM_BITS]   = duty;
            end
            ADDR_PERIOD: readdata[PERIOD_BITS-1:0] = period;
            ADDR_MASK:   readdata[NUM_LEDS-1:0]    = mask;
            default: begin
                readdata[0]                         = phase;
                readdata[CTRL_DUTY_LSB +: PWM_BITS] = pwm_cnt;
            end
        endcase
    end

endmodule

// File: tb/tb_led_pwm_blinker.sv
// Self-checking bench for led_pwm_blinker: directed scenarios followed by random
// bus traffic, compared against a time-based behavioural model.
module tb_led_pwm_blinker;

    logic        clk;
    logic        reset;
    logic [9:0]  led_in;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [9:0]  led_out;

    int n_vec;
    int n_err;

    // Model state: register contents plus edge timestamps of the last reset/restart.
    bit          m_en;
    bit          m_blink;
    logic [7:0]  m_duty;
    logic [23:0] m_period;
    logic [9:0]  m_mask;
    int unsigned t;
    int unsigned pwm_origin;
    int unsigned restart_edge;

    led_pwm_blinker dut (
        .clk        (clk),
        .reset      (reset),
        .led_in     (led_in),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .led_out    (led_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] pwm_count();
        return 8'((t - pwm_origin) % 256);
    endfunction

    function automatic bit phase_now();
        if (m_period == 24'd0) return 1'b1;
        return (((t - restart_edge) / 32'(m_period)) % 2) == 0;
    endfunction

    function automatic logic [9:0] model_led();
        logic [9:0] lit;
        bit on;
        on = (m_duty == 8'hFF) || (pwm_count() < m_duty);
        if (!m_en || !on) return 10'h000;
        lit = led_in;
        if (m_blink && !phase_now()) lit = lit & ~m_mask;
        return lit;
    endfunction

    function automatic logic [31:0] exp_read(input int a);
        case (a)
            0:       return {16'h0, m_duty, 6'h0, m_blink, m_en};
            1:       return {8'h0, m_period};
            2:       return {22'h0, m_mask};
            default: return {16'h0, pwm_count(), 7'h0, phase_now()};
        endcase
    endfunction

    function automatic void model_write(input logic [1:0] a, input logic [31:0] d);
        case (a)
            2'd0: begin
                m_en    = d[0];
                m_blink = d[1];
                m_duty  = d[15:8];
            end
            2'd1: begin
                m_period     = d[23:0];
                restart_edge = t + 1;
            end
            2'd2:    m_mask = d[9:0];
            default: ;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock edge: predict led_out from pre-edge state, update the model, then compare.
    task automatic tick();
        logic [9:0] exp_led;
        if (reset) begin
            exp_led      = 10'h000;
            m_en         = 1'b1;
            m_blink      = 1'b0;
            m_duty       = 8'hFF;
            m_period     = 24'd0;
            m_mask       = 10'h000;
            pwm_origin   = t + 1;
            restart_edge = t + 1;
        end else begin
            exp_led = model_led();
            if (chipselect && !write_n) model_write(address, writedata);
        end
        @(posedge clk);
        t++;
        #1;
        checkOutput("led_out", {22'h0, led_out}, {22'h0, exp_led});
    endtask

    task automatic applyStimulus(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic check_reads();
        for (int a = 0; a < 4; a++) begin
            address    = 2'(a);
            chipselect = 1'b1;
            write_n    = 1'b1;
            #1;
            checkOutput($sformatf("read%0d", a), readdata, exp_read(a));
        end
        chipselect = 1'b0;
    endtask

    initial begin
        int high_cnt;
        int n_full;
        int n_dim;

        n_vec      = 0;
        n_err      = 0;
        t          = 0;
        reset      = 1'b1;
        led_in     = 10'h3FF;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'h0;

        // Reset defaults
        tick();
        tick();
        check_reads();
        checkOutput("ctrl_default", exp_read(0), 32'h0000_FF01);
        reset = 1'b0;
        tick();
        checkOutput("first_after_reset", {22'h0, led_out}, 32'h3FF);

        // Pass-through latency
        led_in = 10'h155;
        tick();
        led_in = 10'h2AA;
        tick();
        checkOutput("pass_through", {22'h0, led_out}, 32'h2AA);

        // PWM duty 0x40 over one full period
        led_in = 10'h001;
        applyStimulus(2'd0, 32'h0000_4001);
        high_cnt = 0;
        for (int i = 0; i < 256; i++) begin
            tick();
            high_cnt += int'(led_out[0]);
        end
        checkOutput("pwm_on_time", 32'(high_cnt), 32'd64);
        applyStimulus(2'd0, 32'h0000_0001);
        high_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            high_cnt += int'(led_out[0]);
        end
        checkOutput("duty_zero", 32'(high_cnt), 32'd0);

        // Blink with half-period 5 on the low nibble
        led_in = 10'h3FF;
        applyStimulus(2'd1, 32'd5);
        applyStimulus(2'd2, 32'h0000_000F);
        applyStimulus(2'd0, 32'h0000_FF03);
        tick();
        n_full = 0;
        n_dim  = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (led_out == 10'h3FF) n_full++;
            if (led_out == 10'h3F0) n_dim++;
        end
        checkOutput("blink_full", 32'(n_full), 32'd10);
        checkOutput("blink_dim", 32'(n_dim), 32'd10);
        check_reads();
        applyStimulus(2'd1, 32'd0);
        tick();
        n_full = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (led_out == 10'h3FF) n_full++;
        end
        checkOutput("period_zero_hold", 32'(n_full), 32'd15);

        // Rewrite PERIOD exactly on the terminal-count edge
        applyStimulus(2'd1, 32'd4);
        tick();
        tick();
        tick();
        applyStimulus(2'd1, 32'd4);
        check_reads();
        address = 2'd3;
        #1;
        checkOutput("restart_phase", {31'h0, readdata[0]}, 32'd1);
        for (int i = 0; i < 6; i++) tick();
        check_reads();

        // Reset mid-blink with a concurrent CTRL write
        reset      = 1'b1;
        address    = 2'd0;
        writedata  = 32'h0;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
        check_reads();
        reset = 1'b0;
        tick();

        // Ignored writes: STATUS and deselected bus
        applyStimulus(2'd2, 32'h0000_0155);
        applyStimulus(2'd3, 32'hFFFF_FFFF);
        address    = 2'd0;
        writedata  = 32'h0;
        chipselect = 1'b0;
        write_n    = 1'b0;
        tick();
        write_n = 1'b1;
        check_reads();

        // Random bus traffic and LED patterns
        for (int i = 0; i < 400; i++) begin
            led_in = 10'($urandom);
            if ($urandom_range(0, 2) == 0) begin
                address    = 2'($urandom_range(0, 3));
                chipselect = 1'($urandom_range(0, 1));
                write_n    = 1'($urandom_range(0, 1));
                writedata  = $urandom;
                if (address == 2'd1) writedata = 32'($urandom_range(0, 6));
                if (address == 2'd0 && $urandom_range(0, 2) == 0) writedata[15:8] = 8'hFF;
                if (address == 2'd0 && $urandom_range(0, 2) != 0) writedata[0] = 1'b1;
                tick();
                chipselect = 1'b0;
                write_n    = 1'b1;
            end else begin
                tick();
            end
            if (i % 16 == 0) check_reads();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/led_pwm_blinker.md
# led_pwm_blinker

Output-conditioning stage placed directly downstream of the 10-bit LED PIO register in the HPS system. It takes the PIO's LED bit vector and drives the physical LED pins. Each pin can be dimmed by global PWM and blinked by a per-pin mask. An Avalon-MM slave with the same zero-wait-state read style as the PIO configures the stage.

## Interface

Parameters:
- NUM_LEDS, 10, width of the LED input and output vectors.
- PWM_BITS, 8, width of the PWM counter and duty field.
- PERIOD_BITS, 24, width of the blink half-period register.

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- led_in  in  NUM_LEDS  LED vector from the PIO's out_port.
- address  in  2  Avalon-MM word address.
- chipselect  in  1  Avalon-MM select.
- write_n  in  1  Avalon-MM write strobe, active low.
- writedata  in  32  Avalon-MM write data.
- readdata  out  32  Avalon-MM read data, combinational, zero wait states.
- led_out  out  NUM_LEDS  registered drive to the physical LED pins.

## Operation

Register map (word addresses):
- 0 CTRL, RW.
  - bit0 enable, reset value 1.
  - bit1 blink_en, reset value 0.
  - bits[8+PWM_BITS-1:8] duty, reset value all-ones.
- 1 PERIOD, RW, bits[PERIOD_BITS-1:0]. Blink half-period in clk cycles. Reset value 0.
- 2 MASK, RW, bits[NUM_LEDS-1:0]. Selects which LEDs blink. Reset value 0.
- 3 STATUS, RO.
  - bit0 blink phase.
  - bits[8+PWM_BITS-1:8] current PWM count.
  - Writes to address 3 are ignored.

Register behaviour:
- A write occurs when chipselect=1 and write_n=0. It updates the addressed register at that clock edge.
- Unused register bits read as 0.

PWM:
- pwm_cnt is a free-running PWM_BITS counter that increments every clk and wraps from all-ones to 0.
- pwm_on = (duty == all-ones) OR (pwm_cnt < duty).
- duty=0 gives pwm_on=0 permanently. duty=all-ones gives pwm_on=1 permanently.

Blink timer:
- blink_cnt counts up from 0. When it reaches PERIOD-1, it resets to 0 and phase toggles.
- PERIOD=0 holds blink_cnt at 0 and phase at 1.
- Any write to PERIOD clears blink_cnt to 0 and sets phase to 1 on the same edge. This write takes priority over a coincident terminal count.

Output equation, registered:
- led_out <= enable ? (led_in & {NUM_LEDS{pwm_on}} & (~(MASK & {NUM_LEDS{blink_en}}) | {NUM_LEDS{phase}})) : 0.

Reset:
- All registers return to their reset values.
- pwm_cnt=0, blink_cnt=0, phase=1, led_out=0.
- Reset asserted mid-blink or mid-PWM takes effect at the next edge, regardless of a concurrent bus write.

## Timing

- led_in to led_out latency: 1 clk.
- Register write to led_out effect: the register updates at write edge N, and led_out reflects it at edge N+1.
- readdata is combinational from address and the current register state, with no wait states.
- STATUS shows pwm_cnt and phase values as of the current cycle.
- Blink full period: 2×PERIOD clk cycles.
- PWM period: 2^PWM_BITS clk cycles, with an on-time of duty cycles.

## Structure

- Shared package led_pkg holds:
  - register offsets: ADDR_CTRL=0, ADDR_PERIOD=1, ADDR_MASK=2, ADDR_STATUS=3;
  - CTRL bit positions: CTRL_EN=0, CTRL_BLINK=1, CTRL_DUTY_LSB=8;
  - the CTRL reset constant.
- Sub-module led_blink_timer contains blink_cnt, phase, and the PERIOD-write restart.
  - Inputs: clk, reset, period, restart.
  - Output: phase.
- The top level contains the Avalon register file, pwm_cnt, and the output register.

## Test plan

- **Reset defaults:** assert reset for 2 cycles with led_in=10'h3FF.
  - Required: led_out=0 during reset; CTRL reads 0x0000FF01; PERIOD and MASK read 0.
  - One cycle after release: led_out=10'h3FF.
- **Pass-through latency:** with defaults, step led_in from 10'h155 to 10'h2AA at edge N.
  - Required: led_out=10'h2AA from edge N+1.
- **PWM duty:** write CTRL=0x00004001 (duty 0x40) with led_in=10'h001. Measure over 256 cycles.
  - Required: led_out[0] high for exactly 64 cycles.
  - Then write duty=0 and confirm led_out stays 0.
- **Blink:** write PERIOD=5, MASK=10'h00F, CTRL=0x0000FF03, with led_in=10'h3FF.
  - Required: led_out alternates between 10'h3FF and 10'h3F0, each for 5 cycles.
  - Then write PERIOD=0 and confirm led_out holds 10'h3FF.
- **Restart and priority:** write PERIOD on the cycle blink_cnt=PERIOD-1.
  - Required: phase=1, no toggle occurs, and STATUS bit0 reads 1.
  - Asserting reset mid-blink returns phase=1 and led_out=0.
- **Ignored writes:** write 0xFFFFFFFF to address 3 and write with chipselect=0.
  - Required: no register changes.
